// File: rtl/adder_pkg.sv
// Shared constants and the per-stage pipeline register layout for pipe_rca_adder.
// The stage struct is sized for DEFAULT_WIDTH, which is also the widest WIDTH the adder accepts.
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 64;
  localparam int DEFAULT_STAGES = 4;

  typedef struct packed {
    logic                     valid;
    logic [DEFAULT_WIDTH-1:0] sum;
    logic                     carry;
    logic [DEFAULT_WIDTH-1:0] a;
    logic [DEFAULT_WIDTH-1:0] b;
    logic                     sub;
  } adder_stage_t;

endpackage

// File: rtl/rca_slice.sv
// Combinational W-bit ripple-carry adder slice built from full-adder cells.
module rca_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_c_in,
  output logic [W-1:0] o_sum,
  output logic         o_c_out
);

  logic [W:0] w_c;

  assign w_c[0] = i_c_in;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign o_sum[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]   = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_c_out = w_c[W];

endmodule

// File: rtl/pipe_rca_adder.sv
// Pipelined ripple-carry adder: the carry chain is cut into STAGES slices with skewed operands.
// Optional subtract mode (op_sub port) is enabled by defining ADDER_SUB_EN.
module pipe_rca_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef ADDER_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int W   = WIDTH / STAGES;
  localparam int MSB = WIDTH - 1;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0 || WIDTH > DEFAULT_WIDTH) begin : g_bad_cfg
    $error("pipe_rca_adder: illegal WIDTH/STAGES combination");
  end

  adder_stage_t     r_stg [STAGES];
  adder_stage_t     w_nxt [STAGES];
  logic             w_adv;
  logic             w_sub;
  logic             w_cin0;
  logic [WIDTH-1:0] w_b_eff;

`ifdef ADDER_SUB_EN
  assign w_sub = op_sub;
`else
  assign w_sub = 1'b0;
`endif

  // Subtraction is a + ~b + 1, so the incoming carry is forced high.
  assign w_b_eff = w_sub ? ~b : b;
  assign w_cin0  = w_sub | c_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_stage_t w_src;
    adder_stage_t w_cur;
    logic [W-1:0] w_s;
    logic         w_co;

    if (k == 0) begin : g_first
      always_comb begin
        w_src       = '0;
        w_src.valid = in_valid;
        w_src.a     = DEFAULT_WIDTH'(a);
        w_src.b     = DEFAULT_WIDTH'(w_b_eff);
        w_src.carry = w_cin0;
        w_src.sub   = w_sub;
      end
    end else begin : g_rest
      assign w_src = r_stg[k-1];
    end

    rca_slice #(.W(W)) u_slice (
      .i_a     (w_src.a[k*W +: W]),
      .i_b     (w_src.b[k*W +: W]),
      .i_c_in  (w_src.carry),
      .o_sum   (w_s),
      .o_c_out (w_co)
    );

    always_comb begin
      w_cur                = w_src;
      w_cur.sum[k*W +: W]  = w_s;
      w_cur.carry          = w_co;
    end

    assign w_nxt[k] = w_cur;
  end

  // The whole pipe freezes together while the output is back-pressured.
  assign w_adv    = ~(out_valid & ~out_ready);
  assign in_ready = w_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) r_stg[k] <= '0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) r_stg[k] <= w_nxt[k];
    end
  end

  assign out_valid = r_stg[STAGES-1].valid;
  assign sum       = r_stg[STAGES-1].sum[WIDTH-1:0];
  assign c_out     = r_stg[STAGES-1].carry;
  assign ovf       = (r_stg[STAGES-1].a[MSB] == r_stg[STAGES-1].b[MSB]) &
                     (r_stg[STAGES-1].sum[MSB] != r_stg[STAGES-1].a[MSB]);

endmodule

// File: tb/tb_pipe_rca_adder.sv
// Self-checking bench for pipe_rca_adder: directed vectors on the 4-stage build,
// stall/reset scenarios, and a random stream shared by 1-, 4- and 64-stage instances.
module tb_pipe_rca_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] a;
  logic [63:0] b;
  logic        c_in;
  logic        r_sub;
  logic        out_ready;

  logic        in_ready4, out_valid4, c_out4, ovf4;
  logic [63:0] sum4;
  logic        in_ready1, out_valid1, c_out1, ovf1;
  logic [63:0] sum1;
  logic        in_ready64, out_valid64, c_out64, ovf64;
  logic [63:0] sum64;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_rca_adder #(.WIDTH(64), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .c_in(c_in),
`ifdef ADDER_SUB_EN
    .op_sub(r_sub),
`endif
    .out_valid(out_valid4), .out_ready(out_ready),
    .sum(sum4), .c_out(c_out4), .ovf(ovf4)
  );

  pipe_rca_adder #(.WIDTH(64), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .c_in(c_in),
`ifdef ADDER_SUB_EN
    .op_sub(r_sub),
`endif
    .out_valid(out_valid1), .out_ready(1'b1),
    .sum(sum1), .c_out(c_out1), .ovf(ovf1)
  );

  pipe_rca_adder #(.WIDTH(64), .STAGES(64)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .a(a), .b(b), .c_in(c_in),
`ifdef ADDER_SUB_EN
    .op_sub(r_sub),
`endif
    .out_valid(out_valid64), .out_ready(1'b1),
    .sum(sum64), .c_out(c_out64), .ovf(ovf64)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {ovf, c_out, sum}.
  function automatic logic [65:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic ci, input logic sub);
    logic [63:0] ye;
    logic [64:0] t;
    logic        v;
    ye = sub ? ~y : y;
    t  = {1'b0, x} + {1'b0, ye} + 65'(sub | ci);
    v  = (x[63] == ye[63]) && (t[63] != x[63]);
    return {v, t};
  endfunction

  task automatic run_vec(input string tag, input logic [63:0] x, input logic [63:0] y,
                         input logic ci, input logic sub, input logic [65:0] exp);
    check({tag, "_rdy"}, in_ready4, 1);
    a = x; b = y; c_in = ci; r_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_early"}, out_valid4, 0);
    @(posedge clk); #1;
    check({tag, "_vld"}, out_valid4, 1);
    check(tag, {ovf4, c_out4, sum4}, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [65:0] q [$];
    logic [65:0] q1 [$];
    logic [65:0] q4 [$];
    logic [65:0] q64 [$];
    logic [65:0] e;
    logic [63:0] x, y;
    logic        ci;
    int          idx, got, held;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; r_sub = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid4, 0);
    check("rst_in_ready", in_ready4, 1);
    check("rst_sum", sum4, 0);
    check("rst_c_out", c_out4, 0);
    check("rst_ovf", ovf4, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_vec("all_ones_plus_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, {1'b0, 1'b1, 64'h0});
    run_vec("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
            {1'b0, 1'b0, 64'h8000_0000_0000_0000} | {1'b1, 65'h0});
    run_vec("small", 64'h1234, 64'h1, 1'b1, 1'b0, {1'b0, 1'b0, 64'h1236});
    run_vec("neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
            {1'b1, 1'b1, 64'h0});
    run_vec("slice_carry", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
            {1'b0, 1'b0, 64'h0000_0001_0000_0000});
    run_vec("multi_carry", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1, 1'b0,
            {1'b0, 1'b0, 64'h0001_0000_0001_0001});
`ifdef ADDER_SUB_EN
    run_vec("sub_5_7", 64'd5, 64'd7, 1'b1, 1'b1, {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    run_vec("sub_7_5", 64'd7, 64'd5, 1'b0, 1'b1, {1'b0, 1'b1, 64'h2});
    r_sub = 1'b0;
`endif

    // Eight back-to-back inputs; output back-pressured for three cycles once the first result lands.
    idx = 0; got = 0; held = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      out_ready = !(c >= 4 && c < 7);
      in_valid  = (idx < 8);
      x = 64'h0F0F_0F0F_F0F0_F0F0 + 64'(idx) * 64'h1111_2222_3333_4444;
      y = 64'hFFFF_0000_FFFF_0000 - 64'(idx);
      ci = idx[0];
      a = x; b = y; c_in = ci;
      #1;
      if (out_valid4 && !out_ready) begin
        held++;
        check("stall_in_ready", in_ready4, 0);
        if (q.size() != 0) check("stall_hold", {ovf4, c_out4, sum4}, q[0]);
      end
      if (out_valid4 && out_ready) begin
        if (q.size() == 0) check("stall_extra", out_valid4, 0);
        else check("stall_result", {ovf4, c_out4, sum4}, q.pop_front());
        got++;
      end
      if (in_valid && in_ready4) begin
        q.push_back(model(x, y, ci, 1'b0));
        idx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stall_count", got, 8);
    check("stall_cycles", held, 3);
    repeat (2) @(posedge clk);
    #1;
    check("stall_no_dup", out_valid4, 0);

    // Reset with three operations in flight, one of them already at the output.
    for (int i = 0; i < 3; i++) begin
      a = 64'h100 + 64'(i); b = 64'h2; c_in = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_valid", out_valid4, 1);
    rst = 1'b1;
    #1;
    check("rst_async_valid", out_valid4, 0);
    check("rst_async_ready", in_ready4, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    run_vec("post_rst", 64'hDEAD_BEEF_0000_0001, 64'h1111_1111_FFFF_FFFF, 1'b1, 1'b0,
            {1'b0, 1'b0, 64'hEFBE_D001_0000_0001});
    for (int i = 0; i < 6; i++) begin
      check("no_stale", out_valid4, 0);
      @(posedge clk); #1;
    end

    // Random stream through all three depths.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 10070; n++) begin
      if (out_valid1) begin
        if (q1.size() == 0) check("rnd1_extra", out_valid1, 0);
        else check("rnd1", {ovf1, c_out1, sum1}, q1.pop_front());
      end
      if (out_valid4) begin
        if (q4.size() == 0) check("rnd4_extra", out_valid4, 0);
        else check("rnd4", {ovf4, c_out4, sum4}, q4.pop_front());
      end
      if (out_valid64) begin
        if (q64.size() == 0) check("rnd64_extra", out_valid64, 0);
        else check("rnd64", {ovf64, c_out64, sum64}, q64.pop_front());
      end
      if (n < 10000) begin
        x = {$urandom, $urandom};
        y = {$urandom, $urandom};
        ci = 1'($urandom_range(0, 1));
        a = x; b = y; c_in = ci; in_valid = 1'b1;
        e = model(x, y, ci, 1'b0);
        q1.push_back(e); q4.push_back(e); q64.push_back(e);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("rnd1_drain", q1.size(), 0);
    check("rnd4_drain", q4.size(), 0);
    check("rnd64_drain", q64.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
